// File: rtl/phase_scheduler.sv
// phase_scheduler: two-group intersection phase sequencer with round-robin preempt arbitration.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   tick          - one-cycle pulse per second
//   mode          - 00 run, 01 night, 1x hold (settings edit)
//   green_len     - main/left-turn green duration in seconds (0 treated as 1)
//   yellow_len    - yellow duration in seconds (0 treated as 1)
//   req           - preempt request pulses, bit0 group1, bit1 group2
//   phase         - current phase code (0 night, 1-8 normal cycle, 9/10 preempt)
//   cnt           - remaining seconds of the current phase
//   grant         - one-hot while a preempt phase runs
//   pending       - latched unserved preempt requests
//   period_start  - one-cycle pulse on every phase entry except night
module phase_scheduler #(
    parameter int CNT_WIDTH   = 11,
    parameter int PREEMPT_LEN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] green_len,
    input  logic [CNT_WIDTH-1:0] yellow_len,
    input  logic [1:0]           req,
    output logic [3:0]           phase,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [1:0]           grant,
    output logic [1:0]           pending,
    output logic                 period_start
);
    typedef enum logic [3:0] {
        NIGHT = 4'd0,
        G1    = 4'd1, G1Y = 4'd2, G1L = 4'd3, G1LY = 4'd4,
        G2    = 4'd5, G2Y = 4'd6, G2L = 4'd7, G2LY = 4'd8,
        PRE1  = 4'd9, PRE2 = 4'd10
    } phase_e;

    localparam logic [CNT_WIDTH-1:0] PRE_LEN = (PREEMPT_LEN < 1) ? CNT_WIDTH'(1) : CNT_WIDTH'(PREEMPT_LEN);

    phase_e               phase_q, phase_d, succ, norm_succ;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, green_eff, yellow_eff, succ_len;
    logic [1:0]           pending_q, pending_d, req_ok;
    logic                 rr_q, rr_d, period_start_q, period_start_d;
    logic                 win, preempt;

    always_comb begin
        green_eff  = (green_len == '0) ? CNT_WIDTH'(1) : green_len;
        yellow_eff = (yellow_len == '0) ? CNT_WIDTH'(1) : yellow_len;
        // a request for the group already being served is redundant
        req_ok     = req & ~{phase_q == PRE2, phase_q == PRE1};
        // rr_q is the last granted group; a tie goes to the other one
        win        = (pending_q == 2'b11) ? ~rr_q : pending_q[1];
        preempt    = (phase_q inside {G1Y, G1LY, G2Y, G2LY, PRE1, PRE2}) && (pending_q != 2'b00);
        norm_succ  = (phase_q == G2LY || phase_q == PRE1) ? G1 :
                     (phase_q == PRE2) ? G2 : phase_e'(phase_q + 4'd1);
        succ       = preempt ? (win ? PRE2 : PRE1) : norm_succ;
        succ_len   = (succ == PRE1 || succ == PRE2) ? PRE_LEN : (succ[0] ? green_eff : yellow_eff);
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q | req_ok;
        rr_d           = rr_q;
        period_start_d = 1'b0;
        if (mode == 2'b01) begin
            phase_d   = NIGHT;
            cnt_d     = '0;
            pending_d = 2'b00;
        end else if (phase_q > PRE2) begin
            phase_d = NIGHT;
            cnt_d   = '0;
        end else if (mode == 2'b00) begin
            if (phase_q == NIGHT) begin
                phase_d        = G1;
                cnt_d          = green_eff;
                period_start_d = 1'b1;
            end else if (tick) begin
                if (cnt_q > CNT_WIDTH'(1)) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    phase_d        = succ;
                    cnt_d          = succ_len;
                    period_start_d = 1'b1;
                    if (preempt) begin
                        pending_d[win] = 1'b0;
                        rr_d           = win;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= NIGHT;
            cnt_q          <= '0;
            pending_q      <= 2'b00;
            rr_q           <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            period_start_q <= period_start_d;
        end
    end

    assign phase        = phase_q;
    assign cnt          = cnt_q;
    assign grant        = {phase_q == PRE2, phase_q == PRE1};
    assign pending      = pending_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed and randomized checks of phase_scheduler against a behavioural model.
module tb_phase_scheduler;
    localparam int CW = 11;
    localparam int PL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] green_len = CW'(8);
    logic [CW-1:0] yellow_len = CW'(6);
    logic [1:0]    req = 2'b00;
    logic [3:0]    phase;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic [1:0]    pending;
    logic          period_start;

    int vectors = 0;
    int miscompares = 0;

    phase_scheduler #(.CNT_WIDTH(CW), .PREEMPT_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode),
        .green_len(green_len), .yellow_len(yellow_len), .req(req),
        .phase(phase), .cnt(cnt), .grant(grant), .pending(pending),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // model state: phase code, seconds left, unserved requests, last granted group
    int         m_phase, m_cnt, m_last, m_who, m_next;
    logic [1:0] m_pend, m_nreq;
    logic       m_ps;
    int         succ_tab [0:10] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 1, 5};

    function automatic int len_of(int p);
        if (p >= 9) return PL;
        if (p % 2 == 1) return (green_len == 0) ? 1 : int'(green_len);
        return (yellow_len == 0) ? 1 : int'(yellow_len);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_pend = 0; m_last = 0; m_ps = 0;
        end else begin
            m_ps = 0;
            m_nreq = req & ~{m_phase == 10, m_phase == 9};
            if (mode == 2'b01) begin
                m_phase = 0; m_cnt = 0; m_pend = 0;
            end else if (mode != 2'b00) begin
                m_pend = m_pend | m_nreq;
            end else if (m_phase == 0 || (tick && m_cnt == 1)) begin
                m_who = -1;
                if (m_phase != 0 && (m_phase % 2 == 0 || m_phase >= 9) && m_pend != 0) begin
                    m_who = (m_pend == 2'b11) ? 1 - m_last : (m_pend[1] ? 1 : 0);
                    m_last = m_who;
                end
                m_next = (m_who < 0) ? succ_tab[m_phase] : 9 + m_who;
                m_pend = m_pend | m_nreq;
                if (m_who >= 0) m_pend[m_who] = 1'b0;
                m_phase = m_next;
                m_cnt = len_of(m_next);
                m_ps = 1;
            end else begin
                m_pend = m_pend | m_nreq;
                if (tick && m_cnt > 1) m_cnt = m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] eg;
        eg = (m_phase == 9) ? 2'b01 : (m_phase == 10) ? 2'b10 : 2'b00;
        vectors++;
        if (int'(phase) != m_phase || int'(cnt) != m_cnt || grant != eg || pending != m_pend || period_start != m_ps) begin
            miscompares++;
            $display("FAIL model t=%0t: phase %0d/%0d cnt %0d/%0d grant %b/%b pending %b/%b period_start %b/%b (got/want)",
                     $time, phase, m_phase, cnt, m_cnt, grant, eg, pending, m_pend, period_start, m_ps);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input logic t, input logic [1:0] r);
        tick = t;
        req = r;
        @(negedge clk);
        tick = 1'b0;
        req = 2'b00;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 2'b00);
            cyc(1'b0, 2'b00);
        end
    endtask

    initial begin
        int budget;
        repeat (2) @(negedge clk);
        chk("reset phase", int'(phase), 0);
        chk("reset cnt", int'(cnt), 0);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00);
        chk("first phase", int'(phase), 1);
        chk("first cnt", int'(cnt), 8);
        chk("first period_start", int'(period_start), 1);
        ticks(8);
        chk("G1Y phase", int'(phase), 2);
        chk("G1Y cnt", int'(cnt), 6);
        ticks(48);
        chk("loop back phase", int'(phase), 1);
        chk("loop back cnt", int'(cnt), 8);

        ticks(28 + 5);
        chk("G2 cnt before req", int'(cnt), 3);
        cyc(1'b0, 2'b01);
        chk("pending g1", int'(pending), 1);
        ticks(3);
        chk("G2Y reached", int'(phase), 6);
        ticks(6);
        chk("PRE1 phase", int'(phase), 9);
        chk("PRE1 cnt", int'(cnt), 5);
        chk("PRE1 grant", int'(grant), 1);
        chk("PRE1 pending", int'(pending), 0);
        ticks(5);
        chk("after PRE1 phase", int'(phase), 1);
        chk("after PRE1 cnt", int'(cnt), 8);

        ticks(14 + 4);
        chk("G1L cnt", int'(cnt), 4);
        mode = 2'b10;
        ticks(10);
        chk("hold phase", int'(phase), 3);
        chk("hold cnt", int'(cnt), 4);
        mode = 2'b00;
        ticks(1);
        chk("resume cnt", int'(cnt), 3);

        ticks(37);
        chk("back to G1", int'(phase), 1);
        cyc(1'b0, 2'b11);
        chk("both pending", int'(pending), 3);
        ticks(14);
        chk("PRE2 phase", int'(phase), 10);
        chk("PRE2 grant", int'(grant), 2);
        chk("PRE2 pending", int'(pending), 1);

        budget = 400;
        while (m_phase != 7 && budget > 0) begin
            cyc(1'b1, 2'b00);
            budget--;
        end
        chk("reach G2L within budget", int'(budget > 0), 1);
        cyc(1'b0, 2'b10);
        mode = 2'b01;
        cyc(1'b0, 2'b00);
        chk("night phase", int'(phase), 0);
        chk("night cnt", int'(cnt), 0);
        chk("night pending", int'(pending), 0);
        chk("night period_start", int'(period_start), 0);

        green_len = '0;
        mode = 2'b00;
        cyc(1'b0, 2'b00);
        chk("zero green phase", int'(phase), 1);
        chk("zero green cnt", int'(cnt), 1);
        ticks(1);
        chk("zero green expiry", int'(phase), 2);
        chk("zero green yellow cnt", int'(cnt), 6);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset phase", int'(phase), 0);
        chk("async reset cnt", int'(cnt), 0);
        chk("async reset pending", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 150 == 0) mode = ($urandom % 3 == 0) ? 2'($urandom % 4) : 2'b00;
            if ($urandom % 100 == 0) green_len = CW'($urandom % 5);
            if ($urandom % 100 == 0) yellow_len = CW'($urandom % 4);
            cyc($urandom % 3 == 0, ($urandom % 12 == 0) ? 2'($urandom % 4) : 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
